// File: rtl/memory_fifo.sv
// Byte FIFO over a 512x8 synchronous dual-port RAM with a
// two-entry first-word-fall-through output stage.
module dual_port_memory #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk_a,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          clk_b,
  input  logic          en_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_a) begin
    if (en_a && we_a) mem[addr_a] <= din_a;
  end

  always_ff @(posedge clk_b) begin
    if (en_b) dout_b <= mem[addr_b];
  end

endmodule

module memory_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] occ;
  logic          alive;
  logic          rd_pend;
  logic          hd_v;
  logic          sk_v;
  logic [DATA_WIDTH-1:0] hd_d;
  logic [DATA_WIDTH-1:0] sk_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic          accept;
  logic          deliver;
  logic          issue;
  logic [1:0]    slots;

  dual_port_memory #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk_a  (clock),
    .en_a   (1'b1),
    .we_a   (accept),
    .addr_a (wr_cnt[ADDR_WIDTH-1:0]),
    .din_a  (in_data),
    .clk_b  (clock),
    .en_b   (1'b1),
    .addr_b (rd_cnt[ADDR_WIDTH-1:0]),
    .dout_b (ram_q)
  );

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = alive && !full;
  assign out_valid = hd_v;
  assign out_data  = hd_d;
  assign accept    = in_valid && in_ready;
  assign deliver   = hd_v && out_ready;
  assign occ       = wr_cnt - rd_cnt;

  // Output-stage occupancy next cycle, including a read in flight.
  assign slots = 2'(hd_v) + 2'(sk_v)
               + 2'(rd_pend) - 2'(deliver);
  assign issue = (occ != '0) && (slots < 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      count   <= '0;
      alive   <= 1'b0;
      rd_pend <= 1'b0;
      hd_v    <= 1'b0;
      sk_v    <= 1'b0;
      hd_d    <= '0;
      sk_d    <= '0;
    end else begin
      alive   <= 1'b1;
      rd_pend <= issue;
      if (accept) wr_cnt <= wr_cnt + CW'(1);
      if (issue)  rd_cnt <= rd_cnt + CW'(1);
      if (accept && !deliver)
        count <= count + CW'(1);
      else if (!accept && deliver)
        count <= count - CW'(1);
      if (!hd_v || deliver) begin
        if (sk_v) begin
          hd_d <= sk_d;
          hd_v <= 1'b1;
          sk_v <= rd_pend;
          if (rd_pend) sk_d <= ram_q;
        end else if (rd_pend) begin
          hd_d <= ram_q;
          hd_v <= 1'b1;
        end else begin
          hd_v <= 1'b0;
        end
      end else if (rd_pend) begin
        // Head stalled: park the arriving byte.
        sk_d <= ram_q;
        sk_v <= 1'b1;
      end
    end
  end

endmodule

// File: doc/memory_fifo.md
MEMORY_FIFO -- requirements
Module: memory_fifo

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, byte width; only 8 is supported, matching the 512x8 dual_port_memory.
REQ-002 SHALL have parameter: ADDR_WIDTH, 9, RAM address width; capacity = 2**ADDR_WIDTH = 512 entries.
REQ-003 SHALL have port: clock  input  1  single clock for all logic and both RAM ports.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_data  input  8  write-side byte.
REQ-006 SHALL have port: in_valid  input  1  in_data is offered.
REQ-007 SHALL have port: in_ready  output  1  FIFO accepts in_data this cycle.
REQ-008 SHALL have port: out_data  output  8  read-side byte (first-word-fall-through).
REQ-009 SHALL have port: out_valid  output  1  out_data holds a valid byte.
REQ-010 SHALL have port: out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port: count  output  10  bytes accepted but not yet delivered, 0..512.
REQ-012 SHALL have port: full  output  1  count == 512.
REQ-013 SHALL have port: empty  output  1  count == 0.

Function
REQ-014 SHALL instantiate one dual_port_memory for storage, with both clocks tied to clock and both clock enables tied high.
REQ-015 SHALL accept a byte on a rising edge when in_valid && in_ready; in_ready = !full, combinational from registered count.
REQ-016 SHALL deliver a byte on a rising edge when out_valid && out_ready.
REQ-017 SHALL write accepted bytes to RAM at wr_ptr; wr_ptr is 9 bits and wraps 511 -> 0.
REQ-018 SHALL read RAM at rd_ptr; rd_ptr is 9 bits and wraps 511 -> 0; RAM read data is valid one cycle after the read is issued.
REQ-019 SHALL issue a RAM read only when RAM occupancy (wr_ptr - rd_ptr, taken from registered pointers, 10-bit with full flag) > 0 and the output stage will have a free slot, counting reads in flight.
REQ-020 SHALL never read the address being written in the same cycle; a byte written on edge N is first readable on the cycle after edge N.
REQ-021 SHALL hold an output stage of two registers (head, skid) so that out_valid stays high and throughput is 1 byte/cycle while out_ready=1 and data is available.
REQ-022 SHALL deliver bytes in exact acceptance order, without loss or duplication.
REQ-023 SHALL have latency: byte accepted on edge N into an empty FIFO -> out_valid=1 with that byte after edge N+2.
REQ-024 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL update count +1 on accept only, -1 on deliver only, and leave it unchanged on both in one cycle.
REQ-026 SHALL, when full and a deliver occurs, keep in_ready at 0 that cycle; the slot frees after the edge.
REQ-027 SHALL, when empty, ignore out_ready; out_data is don't-care but held at its last value.
REQ-028 SHALL treat in_valid with in_ready=0 as no operation; no pointer, count or RAM change.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, in_ready=0, full=0, empty=1, and clear the output stage and the in-flight read flag.
REQ-030 SHALL assert in_ready=1 on the first cycle after reset_n rises; RAM contents are not cleared.
REQ-031 SHALL, on reset mid-operation, discard all stored and in-flight bytes; no pre-reset byte appears at out_data afterwards.

Verification
REQ-032 SHALL cover single byte: push 0xA5 at edge 0, out_ready=1 -> out_valid=1, out_data=0xA5 after edge 2; count 1 then 0; empty=1 after delivery.
REQ-033 SHALL cover fill: push 0..511 (byte = index mod 256) with out_ready=0 -> count=512, full=1, in_ready=0; 513th offer not accepted; drain returns 0..511 in order.
REQ-034 SHALL cover full with simultaneous accept and deliver: at full, out_ready=1, in_valid=1 -> that cycle in_ready=0; next cycle one accept + one deliver each cycle, count stays 511/512, order preserved.
REQ-035 SHALL cover streaming: 1000 bytes, in_valid=1 and out_ready=1 continuously -> after the 2-cycle initial latency, one byte per cycle with no bubbles; pointers wrap; data checked in order.
REQ-036 SHALL cover random backpressure: random in_valid/out_ready at 50% for 5000 bytes -> scoreboard matches; out_data never changes while stalled.
REQ-037 SHALL cover reset mid-stream: 300 bytes stored, reset_n pulsed low for 1 cycle away from a clock edge -> immediately count=0, out_valid=0; then push 0x3C -> 0x3C is the first byte delivered.
